// File: rtl/hps_pio_pkg.sv
// Shared definitions for the hps_pio_bank multi-channel PIO slave.
// Register offsets, edge-mode encodings and the channel address width helper.
package hps_pio_pkg;

    // Per-channel register offsets (low 3 address bits)
    localparam logic [2:0] OFF_DATA     = 3'd0;
    localparam logic [2:0] OFF_IN       = 3'd1;
    localparam logic [2:0] OFF_IRQ_MASK = 3'd2;
    localparam logic [2:0] OFF_EDGE_CAP = 3'd3;
    localparam logic [2:0] OFF_OUTSET   = 3'd4;
    localparam logic [2:0] OFF_OUTCLR   = 3'd5;

    // Edge capture modes
    localparam int unsigned EDGE_RISE = 0;
    localparam int unsigned EDGE_FALL = 1;
    localparam int unsigned EDGE_ANY  = 2;

    // Channel index width: at least one bit even for a single channel
    function automatic int unsigned ch_aw(input int unsigned num_ch);
        return (num_ch <= 2) ? 1 : $clog2(num_ch);
    endfunction

endpackage

// File: rtl/hps_pio_channel.sv
// One PIO channel: output register with set/clear, 2-flop input synchroniser,
// and (with HPS_PIO_IRQ_EN defined) edge capture, interrupt mask and irq term.
// Read value for the addressed offset is combinational; the top registers it.
module hps_pio_channel
    import hps_pio_pkg::*;
#(
    parameter int unsigned       WIDTH       = 8,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0,
    parameter int unsigned       EDGE_TYPE   = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_we,
    input  logic [2:0]       i_offset,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [WIDTH-1:0] i_in,
    output logic [WIDTH-1:0] o_out,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_irq_term
);

    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;

    // Output register: plain write, atomic set and atomic clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data <= RESET_VALUE;
        end else if (i_we) begin
            case (i_offset)
                OFF_DATA:   r_data <= i_wdata;
                OFF_OUTSET: r_data <= r_data | i_wdata;
                OFF_OUTCLR: r_data <= r_data & ~i_wdata;
                default:    r_data <= r_data;
            endcase
        end
    end

    // Two-flop synchroniser for the asynchronous input pins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= i_in;
            r_s2 <= r_s1;
        end
    end

    assign o_out = r_data;

`ifdef HPS_PIO_IRQ_EN
    logic [WIDTH-1:0] r_s3;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_edge_cap;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_w1c;

    // Edge term from the synchronised value and its one-cycle delay
    always_comb begin
        if (EDGE_TYPE == EDGE_FALL) begin
            w_edge = ~r_s2 & r_s3;
        end else if (EDGE_TYPE == EDGE_ANY) begin
            w_edge = r_s2 ^ r_s3;
        end else begin
            w_edge = r_s2 & ~r_s3;
        end
        w_w1c = (i_we && (i_offset == OFF_EDGE_CAP)) ? i_wdata : '0;
    end

    // Delay flop, mask register and sticky capture; a new edge beats a clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s3       <= '0;
            r_mask     <= '0;
            r_edge_cap <= '0;
        end else begin
            r_s3       <= r_s2;
            r_edge_cap <= (r_edge_cap & ~w_w1c) | w_edge;
            if (i_we && (i_offset == OFF_IRQ_MASK)) begin
                r_mask <= i_wdata;
            end
        end
    end

    assign o_irq_term = |(r_edge_cap & r_mask);
`else
    assign o_irq_term = 1'b0;
`endif

    // Read value for the addressed offset; unimplemented offsets read 0
    always_comb begin
        o_rdata = '0;
        case (i_offset)
            OFF_DATA:     o_rdata = r_data;
            OFF_IN:       o_rdata = r_s2;
`ifdef HPS_PIO_IRQ_EN
            OFF_IRQ_MASK: o_rdata = r_mask;
            OFF_EDGE_CAP: o_rdata = r_edge_cap;
`endif
            default:      o_rdata = '0;
        endcase
    end

endmodule

// File: rtl/hps_pio_bank.sv
// Multi-channel Avalon-MM PIO slave for the HPS lightweight bridge.
// Address = {channel, offset}; reads have a fixed one-cycle latency.
// Define HPS_PIO_IRQ_EN to build the mask/edge-capture/interrupt logic;
// without it irq is constant 0 and offsets 2/3 read 0.
module hps_pio_bank
    import hps_pio_pkg::*;
#(
    parameter int unsigned        WIDTH       = 8,
    parameter int unsigned        NUM_CH      = 4,
    parameter logic [WIDTH-1:0]   RESET_VALUE = '0,
    parameter int unsigned        EDGE_TYPE   = EDGE_RISE,
    localparam int unsigned       CH_AW       = ch_aw(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [CH_AW+2:0]        address,
    input  logic                    chipselect,
    input  logic                    write_n,
    input  logic                    read_n,
    input  logic [31:0]             writedata,
    output logic [31:0]             readdata,
    output logic                    readdatavalid,
    output logic [NUM_CH*WIDTH-1:0] out_port,
    input  logic [NUM_CH*WIDTH-1:0] in_port,
    output logic                    irq
);

    logic [CH_AW-1:0] w_ch;
    logic [2:0]       w_off;
    logic             w_wr;
    logic             w_rd;
    logic [NUM_CH-1:0] w_sel;
    logic [NUM_CH-1:0] w_irq_term;
    logic [WIDTH-1:0]  w_ch_rdata [NUM_CH];
    logic [WIDTH-1:0]  w_rd_mux;

    logic [31:0] r_readdata;
    logic        r_readdatavalid;
    logic        r_irq;

    assign w_ch  = address[CH_AW+2:3];
    assign w_off = address[2:0];
    assign w_wr  = chipselect && !write_n;
    assign w_rd  = chipselect && !read_n;

    if (WIDTH < 32) begin : g_wdata_unused
        logic w_unused_wdata;
        assign w_unused_wdata = ^writedata[31:WIDTH];
    end

    // Channel indices at or above NUM_CH match no select line
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign w_sel[c] = (w_ch == CH_AW'(c));

        hps_pio_channel #(
            .WIDTH       (WIDTH),
            .RESET_VALUE (RESET_VALUE),
            .EDGE_TYPE   (EDGE_TYPE)
        ) u_channel (
            .clk        (clk),
            .reset_n    (reset_n),
            .i_we       (w_wr && w_sel[c]),
            .i_offset   (w_off),
            .i_wdata    (writedata[WIDTH-1:0]),
            .i_in       (in_port[c*WIDTH +: WIDTH]),
            .o_out      (out_port[c*WIDTH +: WIDTH]),
            .o_rdata    (w_ch_rdata[c]),
            .o_irq_term (w_irq_term[c])
        );
    end

    // Read mux over channels; unselected or out-of-range reads give 0
    always_comb begin
        w_rd_mux = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_sel[c]) begin
                w_rd_mux = w_ch_rdata[c];
            end
        end
    end

    // Registered read response, valid pulse and interrupt
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata      <= '0;
            r_readdatavalid <= 1'b0;
            r_irq           <= 1'b0;
        end else begin
            r_readdatavalid <= w_rd;
            if (w_rd) begin
                r_readdata <= 32'(w_rd_mux);
            end
            r_irq <= |w_irq_term;
        end
    end

    assign readdata      = r_readdata;
    assign readdatavalid = r_readdatavalid;
    assign irq           = r_irq;

endmodule

// File: tb/tb_hps_pio_bank.sv
// Directed self-checking bench for hps_pio_bank (WIDTH=8, NUM_CH=5 so that
// channel indices 5..7 are addressable but out of range).
module tb_hps_pio_bank;

    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [AW-1:0] address = '0;
    logic          chipselect = 1'b0;
    logic          write_n = 1'b1;
    logic          read_n = 1'b1;
    logic [31:0]   writedata = '0;
    logic [31:0]   readdata;
    logic          readdatavalid;
    logic [39:0]   out_port;
    logic [39:0]   in_port = '0;
    logic          irq;

    int vectors = 0;
    int miscompares = 0;

    hps_pio_bank #(
        .WIDTH       (8),
        .NUM_CH      (5),
        .RESET_VALUE (8'h00),
        .EDGE_TYPE   (0)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .address       (address),
        .chipselect    (chipselect),
        .write_n       (write_n),
        .read_n        (read_n),
        .writedata     (writedata),
        .readdata      (readdata),
        .readdatavalid (readdatavalid),
        .out_port      (out_port),
        .in_port       (in_port),
        .irq           (irq)
    );

    always #5 clk = ~clk;

    function automatic logic [AW-1:0] addr(input int ch, input int off);
        logic [2:0] c3;
        logic [2:0] o3;
        c3 = ch[2:0];
        o3 = off[2:0];
        return {c3, o3};
    endfunction

    task automatic wr(input int ch, input int off, input logic [31:0] d);
        @(negedge clk);
        address = addr(ch, off);
        writedata = d;
        chipselect = 1'b1;
        write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n = 1'b1;
    endtask

    // d/v1: response one cycle after the strobe; d2/v2: the cycle after that
    task automatic rd(input int ch, input int off, output logic [31:0] d, output logic v1,
                      output logic [31:0] d2, output logic v2);
        @(negedge clk);
        address = addr(ch, off);
        chipselect = 1'b1;
        read_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        read_n = 1'b1;
        d = readdata;
        v1 = readdatavalid;
        @(negedge clk);
        d2 = readdata;
        v2 = readdatavalid;
    endtask

    task automatic test_reset();
        logic [31:0] d, d2;
        logic v1, v2;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (out_port !== 40'h0) begin
            miscompares++;
            $display("FAIL reset_out_port: got %h expected %h", out_port, 40'h0);
        end
        vectors++;
        if (readdatavalid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_rdv: got %b expected 0", readdatavalid);
        end
        vectors++;
        if (irq !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_irq: got %b expected 0", irq);
        end
        reset_n = 1'b1;
        rd(0, 0, d, v1, d2, v2);
        vectors++;
        if (d !== 32'h0 || v1 !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_read_data: got %h/%b expected 00000000/1", d, v1);
        end
        vectors++;
        if (v2 !== 1'b0 || d2 !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_read_pulse: got rdv %b data %h expected 0/00000000", v2, d2);
        end
    endtask

    task automatic test_set_clear();
        logic [31:0] d, d2;
        logic v1, v2;
        wr(2, 0, 32'hA5);
        vectors++;
        if (out_port[23:16] !== 8'hA5) begin
            miscompares++;
            $display("FAIL data_write: got %h expected a5", out_port[23:16]);
        end
        wr(2, 4, 32'h0A);
        vectors++;
        if (out_port[23:16] !== 8'hAF) begin
            miscompares++;
            $display("FAIL outset: got %h expected af", out_port[23:16]);
        end
        wr(2, 5, 32'h81);
        vectors++;
        if (out_port[23:16] !== 8'h2E) begin
            miscompares++;
            $display("FAIL outclr: got %h expected 2e", out_port[23:16]);
        end
        vectors++;
        if (out_port[15:0] !== 16'h0 || out_port[39:24] !== 16'h0) begin
            miscompares++;
            $display("FAIL other_channels: got %h expected 0000__0000", out_port);
        end
        rd(2, 0, d, v1, d2, v2);
        vectors++;
        if (d !== 32'h2E || v1 !== 1'b1) begin
            miscompares++;
            $display("FAIL data_readback: got %h/%b expected 0000002e/1", d, v1);
        end
    endtask

    task automatic test_back_to_back();
        // Writes on consecutive edges to channel 3
        @(negedge clk);
        chipselect = 1'b1;
        write_n = 1'b0;
        address = addr(3, 0);
        writedata = 32'h3C;
        @(negedge clk);
        vectors++;
        if (out_port[31:24] !== 8'h3C) begin
            miscompares++;
            $display("FAIL b2b_data: got %h expected 3c", out_port[31:24]);
        end
        address = addr(3, 4);
        writedata = 32'hC0;
        @(negedge clk);
        vectors++;
        if (out_port[31:24] !== 8'hFC) begin
            miscompares++;
            $display("FAIL b2b_outset: got %h expected fc", out_port[31:24]);
        end
        address = addr(3, 5);
        writedata = 32'h0F;
        @(negedge clk);
        write_n = 1'b1;
        vectors++;
        if (out_port[31:24] !== 8'hF0) begin
            miscompares++;
            $display("FAIL b2b_outclr: got %h expected f0", out_port[31:24]);
        end
        // Reads on consecutive edges
        read_n = 1'b0;
        address = addr(2, 0);
        @(negedge clk);
        vectors++;
        if (readdata !== 32'h2E || readdatavalid !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_read0: got %h/%b expected 0000002e/1", readdata, readdatavalid);
        end
        address = addr(3, 0);
        @(negedge clk);
        vectors++;
        if (readdata !== 32'hF0 || readdatavalid !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_read1: got %h/%b expected 000000f0/1", readdata, readdatavalid);
        end
        address = addr(0, 0);
        @(negedge clk);
        chipselect = 1'b0;
        read_n = 1'b1;
        vectors++;
        if (readdata !== 32'h0 || readdatavalid !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_read2: got %h/%b expected 00000000/1", readdata, readdatavalid);
        end
    endtask

    task automatic test_in_port();
        logic [31:0] d, d2;
        logic v1, v2;
        // Continuous read of ch0 IN while the pin changes
        @(negedge clk);
        in_port[7:0] = 8'h33;
        address = addr(0, 1);
        chipselect = 1'b1;
        read_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (readdata !== 32'h0) begin
            miscompares++;
            $display("FAIL in_latency_early: got %h expected 00000000", readdata);
        end
        @(negedge clk);
        chipselect = 1'b0;
        read_n = 1'b1;
        vectors++;
        if (readdata !== 32'h33 || readdatavalid !== 1'b1) begin
            miscompares++;
            $display("FAIL in_latency: got %h/%b expected 00000033/1", readdata, readdatavalid);
        end
        @(negedge clk);
        in_port[15:8] = 8'h5A;
        wr(1, 1, 32'hFF);
        @(negedge clk);
        rd(1, 1, d, v1, d2, v2);
        vectors++;
        if (d !== 32'h5A) begin
            miscompares++;
            $display("FAIL in_ro: got %h expected 0000005a", d);
        end
        vectors++;
        if (out_port[15:8] !== 8'h00) begin
            miscompares++;
            $display("FAIL in_write_ignored: got %h expected 00", out_port[15:8]);
        end
    endtask

    task automatic test_reserved();
        logic [31:0] d, d2;
        logic v1, v2;
        wr(0, 0, 32'h77);
        wr(0, 6, 32'hFF);
        wr(0, 7, 32'hFF);
        vectors++;
        if (out_port[7:0] !== 8'h77) begin
            miscompares++;
            $display("FAIL reserved_write: got %h expected 77", out_port[7:0]);
        end
        for (int off = 4; off < 8; off++) begin
            rd(0, off, d, v1, d2, v2);
            vectors++;
            if (d !== 32'h0 || v1 !== 1'b1) begin
                miscompares++;
                $display("FAIL read_offset%0d: got %h/%b expected 00000000/1", off, d, v1);
            end
        end
    endtask

    task automatic test_rw_same();
        @(negedge clk);
        address = addr(0, 0);
        writedata = 32'h11;
        chipselect = 1'b1;
        write_n = 1'b0;
        read_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n = 1'b1;
        read_n = 1'b1;
        vectors++;
        if (readdata !== 32'h77 || readdatavalid !== 1'b1) begin
            miscompares++;
            $display("FAIL rw_old_value: got %h/%b expected 00000077/1", readdata, readdatavalid);
        end
        vectors++;
        if (out_port[7:0] !== 8'h11) begin
            miscompares++;
            $display("FAIL rw_write: got %h expected 11", out_port[7:0]);
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] d, d2;
        logic v1, v2;
        wr(4, 0, 32'hABCDEF12);
        rd(4, 0, d, v1, d2, v2);
        vectors++;
        if (d !== 32'h12) begin
            miscompares++;
            $display("FAIL wide_write_trunc: got %h expected 00000012", d);
        end
        wr(5, 0, 32'hFF);
        wr(7, 4, 32'hFF);
        vectors++;
        if (out_port !== 40'h12_F0_2E_00_11) begin
            miscompares++;
            $display("FAIL oor_write: got %h expected 12f02e0011", out_port);
        end
        rd(5, 0, d, v1, d2, v2);
        vectors++;
        if (d !== 32'h0 || v1 !== 1'b1 || v2 !== 1'b0) begin
            miscompares++;
            $display("FAIL oor_read: got %h/%b/%b expected 00000000/1/0", d, v1, v2);
        end
    endtask

`ifdef HPS_PIO_IRQ_EN
    task automatic test_irq();
        logic [31:0] d, d2;
        logic v1, v2;
        logic exp_irq;
        wr(1, 3, 32'hFF);
        wr(0, 3, 32'hFF);
        wr(1, 2, 32'h01);
        rd(1, 2, d, v1, d2, v2);
        vectors++;
        if (d !== 32'h01) begin
            miscompares++;
            $display("FAIL mask_readback: got %h expected 00000001", d);
        end
        // Rising edge on in_port[8]: capture at edge 3, irq at edge 4
        @(negedge clk);
        in_port[8] = 1'b1;
        for (int cyc = 1; cyc <= 4; cyc++) begin
            @(negedge clk);
            exp_irq = (cyc >= 4);
            vectors++;
            if (irq !== exp_irq) begin
                miscompares++;
                $display("FAIL irq_latency_c%0d: got %b expected %b", cyc, irq, exp_irq);
            end
        end
        rd(1, 3, d, v1, d2, v2);
        vectors++;
        if (d !== 32'h01) begin
            miscompares++;
            $display("FAIL edge_cap: got %h expected 00000001", d);
        end
        wr(1, 3, 32'h01);
        vectors++;
        if (irq !== 1'b1) begin
            miscompares++;
            $display("FAIL w1c_irq_hold: got %b expected 1", irq);
        end
        @(negedge clk);
        vectors++;
        if (irq !== 1'b0) begin
            miscompares++;
            $display("FAIL w1c_irq_clear: got %b expected 0", irq);
        end
        // Falling edge is not captured in rising mode
        in_port[8] = 1'b0;
        repeat (5) @(negedge clk);
        rd(1, 3, d, v1, d2, v2);
        vectors++;
        if (d !== 32'h0 || irq !== 1'b0) begin
            miscompares++;
            $display("FAIL fall_ignored: got %h/%b expected 00000000/0", d, irq);
        end
        // Edge lands on the same edge as the W1C of that bit
        @(negedge clk);
        in_port[8] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        address = addr(1, 3);
        writedata = 32'h01;
        chipselect = 1'b1;
        write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (irq !== 1'b1) begin
            miscompares++;
            $display("FAIL set_wins_irq: got %b expected 1", irq);
        end
        rd(1, 3, d, v1, d2, v2);
        vectors++;
        if (d !== 32'h01 || irq !== 1'b1) begin
            miscompares++;
            $display("FAIL set_wins_cap: got %h/%b expected 00000001/1", d, irq);
        end
    endtask
`else
    task automatic test_no_irq();
        logic [31:0] d, d2;
        logic v1, v2;
        wr(1, 2, 32'h01);
        @(negedge clk);
        in_port[8] = 1'b1;
        repeat (5) @(negedge clk);
        vectors++;
        if (irq !== 1'b0) begin
            miscompares++;
            $display("FAIL irq_disabled: got %b expected 0", irq);
        end
        rd(1, 2, d, v1, d2, v2);
        vectors++;
        if (d !== 32'h0 || v1 !== 1'b1) begin
            miscompares++;
            $display("FAIL mask_absent: got %h/%b expected 00000000/1", d, v1);
        end
        rd(1, 3, d, v1, d2, v2);
        vectors++;
        if (d !== 32'h0 || v1 !== 1'b1) begin
            miscompares++;
            $display("FAIL edge_cap_absent: got %h/%b expected 00000000/1", d, v1);
        end
    endtask
`endif

    task automatic test_reset_mid_read();
        logic [31:0] d, d2;
        logic v1, v2;
        @(negedge clk);
        address = addr(2, 0);
        chipselect = 1'b1;
        read_n = 1'b0;
        @(negedge clk);
        vectors++;
        if (readdatavalid !== 1'b1) begin
            miscompares++;
            $display("FAIL midread_valid: got %b expected 1", readdatavalid);
        end
        reset_n = 1'b0;
        #1;
        vectors++;
        if (readdatavalid !== 1'b0) begin
            miscompares++;
            $display("FAIL midread_rdv_drop: got %b expected 0", readdatavalid);
        end
        vectors++;
        if (out_port !== 40'h0 || irq !== 1'b0) begin
            miscompares++;
            $display("FAIL midread_state: got %h/%b expected 0000000000/0", out_port, irq);
        end
        chipselect = 1'b0;
        read_n = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (readdatavalid !== 1'b0) begin
            miscompares++;
            $display("FAIL midread_no_late_rsp: got %b expected 0", readdatavalid);
        end
        rd(2, 0, d, v1, d2, v2);
        vectors++;
        if (d !== 32'h0 || v1 !== 1'b1) begin
            miscompares++;
            $display("FAIL post_reset_read: got %h/%b expected 00000000/1", d, v1);
        end
    endtask

    initial begin
        test_reset();
        test_set_clear();
        test_back_to_back();
        test_in_port();
        test_reserved();
        test_rw_same();
        test_out_of_range();
`ifdef HPS_PIO_IRQ_EN
        test_irq();
`else
        test_no_irq();
`endif
        test_reset_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
